axi_lite_master_port: RTL and testbench

- AXI4-Lite initiator that turns a simple single-outstanding CPU memory request into AXI read or write transactions.
- It drives the same read/write channel set the RAM responder accepts: ar/r, aw/w/b.
- The read data channel carries no rresp.
- It sits inside CPU between the fetch/LSU arbiter and the top-level AXI wires, with one transaction in flight at a time.

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_master_port_if.sv | 43 ++++
 rtl/axi_lite_wr_issue.sv | 49 ++++
 rtl/axi_lite_master_port.sv | 125 ++++++++++++
 tb/tb_axi_lite_master_port.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master port: FSM states, BRESP codes
// and default bus widths.
package axi_lite_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/axi_lite_master_port_if.sv
// AXI4-Lite channel bundle (ar/r, aw/w/b; no rresp) with initiator and
// responder views.
interface axi_lite_master_port_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input  arready,
        input  rdata,  rvalid,  output rready,
        output awaddr, awvalid, input  awready,
        output wdata,  wstrb,   wvalid, input wready,
        input  bresp,  bvalid,  output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata,  rvalid,  input  rready,
        input  awaddr, awvalid, output awready,
        input  wdata,  wstrb,   wvalid, output wready,
        output bresp,  bvalid,  input  bready
    );

endinterface

// File: rtl/axi_lite_wr_issue.sv
// Issues AW and W together and retires each independently; both_done_o fires
// in the cycle the second of the two handshakes completes.
module axi_lite_wr_issue
    import axi_lite_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic awready_i,
    input  logic wready_i,
    output logic awvalid_o,
    output logic wvalid_o,
    output logic both_done_o
);

    logic aw_done_q, aw_done_d;
    logic w_done_q,  w_done_d;
    logic aw_hs, w_hs;

    // Valids come straight from registered state, so they never depend on ready.
    assign awvalid_o   = active_i & ~aw_done_q;
    assign wvalid_o    = active_i & ~w_done_q;
    assign aw_hs       = awvalid_o & awready_i;
    assign w_hs        = wvalid_o & wready_i;
    assign both_done_o = active_i & (aw_done_q | aw_hs) & (w_done_q | w_hs);

    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        if (both_done_o) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI4-Lite initiator: turns one CPU request at a time into
// an AR/R read or an AW/W/B write and returns a single response.
module axi_lite_master_port
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [ADDR_W-1:0]      req_addr_i,
    input  logic [DATA_W-1:0]      req_wdata_i,
    input  logic [DATA_W/8-1:0]    req_wstrb_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [DATA_W-1:0]      resp_rdata_o,
    output logic                   resp_err_o,
    axi_lite_master_port_if.master axi
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q,   err_d;
    logic                both_done;

    axi_lite_wr_issue u_wr_issue (
        .clk         (clk),
        .rst         (rst),
        .active_i    (state_q == ST_WR_REQ),
        .awready_i   (axi.awready),
        .wready_i    (axi.wready),
        .awvalid_o   (axi.awvalid),
        .wvalid_o    (axi.wvalid),
        .both_done_o (both_done)
    );

    // Every handshake output decodes the state register alone, so reset drops
    // them immediately and no ready ever feeds back into a valid.
    assign req_ready_o  = (state_q == ST_IDLE);
    assign axi.arvalid  = (state_q == ST_RD_ADDR);
    assign axi.rready   = (state_q == ST_RD_DATA);
    assign axi.bready   = (state_q == ST_WR_RESP);
    assign resp_valid_o = (state_q == ST_RESP);

    assign axi.araddr   = addr_q;
    assign axi.awaddr   = addr_q;
    assign axi.wdata    = wdata_q;
    assign axi.wstrb    = wstrb_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    state_d = req_we_i ? ST_WR_REQ : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (axi.arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (axi.rvalid) begin
                    rdata_d = axi.rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_WR_REQ: begin
                if (both_done) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (axi.bvalid) begin
                    rdata_d = '0;
                    err_d   = (axi.bresp != BRESP_OKAY);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Back to IDLE only; the next request waits one cycle.
                if (resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Self-checking bench: directed vector table, reset/spurious-response
// sequences, then randomized traffic against a latency/response model.
module tb_axi_lite_master_port;
    import axi_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            req_valid, req_ready, req_we;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [DW/8-1:0] req_wstrb;
    logic            resp_valid, resp_ready, resp_err;
    logic [DW-1:0]   resp_rdata;

    axi_lite_master_port_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axi_lite_master_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .axi          (axi)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- responder (stall counts set by the test) ----------------
    int          ar_cfg, r_cfg, aw_cfg, w_cfg, b_cfg;
    logic [31:0] rd_val;
    logic [1:0]  bresp_val;
    bit          spur;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    initial begin
        bit ar_armed, aw_armed, w_armed, r_pend, b_pend, aw_got, w_got, r_show, b_show;
        bit ar_fire, r_fire, aw_fire, w_fire, b_fire;
        int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.rvalid = 1'b0; axi.bvalid = 1'b0; axi.rdata = '0; axi.bresp = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                {ar_armed, aw_armed, w_armed, r_pend, b_pend, aw_got, w_got, r_show, b_show} = '0;
                {ar_fire, r_fire, aw_fire, w_fire, b_fire} = '0;
                axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
                axi.rvalid = 1'b0; axi.bvalid = 1'b0;
                continue;
            end
            if (ar_fire) begin axi.arready = 1'b0; ar_armed = 0; r_pend = 1; r_cnt = r_cfg; end
            if (r_fire)  begin r_show = 0; r_pend = 0; end
            if (aw_fire) begin axi.awready = 1'b0; aw_armed = 0; aw_got = 1; end
            if (w_fire)  begin axi.wready = 1'b0; w_armed = 0; w_got = 1; end
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = b_cfg; end
            if (b_fire)  begin b_show = 0; b_pend = 0; end

            if (axi.arvalid && !axi.arready) begin
                if (!ar_armed) begin ar_armed = 1; ar_cnt = ar_cfg; end
                if (ar_cnt == 0) axi.arready = 1'b1; else ar_cnt--;
            end
            if (axi.awvalid && !axi.awready) begin
                if (!aw_armed) begin aw_armed = 1; aw_cnt = aw_cfg; end
                if (aw_cnt == 0) axi.awready = 1'b1; else aw_cnt--;
            end
            if (axi.wvalid && !axi.wready) begin
                if (!w_armed) begin w_armed = 1; w_cnt = w_cfg; end
                if (w_cnt == 0) axi.wready = 1'b1; else w_cnt--;
            end
            if (r_pend && !r_show) begin if (r_cnt == 0) r_show = 1; else r_cnt--; end
            if (b_pend && !b_show) begin if (b_cnt == 0) b_show = 1; else b_cnt--; end

            axi.rvalid = spur | r_show;
            axi.rdata  = r_show ? rd_val : 32'hBAD0_BAD0;
            axi.bvalid = spur | b_show;
            axi.bresp  = b_show ? bresp_val : BRESP_DECERR;

            ar_fire = axi.arvalid && axi.arready;
            r_fire  = axi.rvalid && axi.rready && r_show;
            aw_fire = axi.awvalid && axi.awready;
            w_fire  = axi.wvalid && axi.wready;
            b_fire  = axi.bvalid && axi.bready && b_show;
            if (ar_fire) cap_araddr = axi.araddr;
            if (aw_fire) cap_awaddr = axi.awaddr;
            if (w_fire) begin cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
        end
    end

    // ---------------- protocol monitor, sampled at the falling edge ----------------
    logic        p_valid, p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rv, p_rr, p_bv, p_br;
    logic        p_rsv, p_rsr, p_err;
    logic [31:0] p_araddr, p_awaddr, p_wdata, p_rdata;
    logic [3:0]  p_wstrb;
    bit          ar_ok, aw_ok, w_ok;
    int          n_resp = 0;
    int          n_req = 0;

    task automatic mon_clear();
        p_valid = 1'b0; ar_ok = 0; aw_ok = 0; w_ok = 0;
    endtask

    task automatic monitor();
        if (rst) begin mon_clear(); return; end
        if (p_valid) begin
            if (p_arv && p_arr) begin check("ar_drop", axi.arvalid, 0); ar_ok = 1; end
            else if (p_arv) check("ar_stable", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
            if (p_awv && p_awr) begin check("aw_drop", axi.awvalid, 0); aw_ok = 1; end
            else if (p_awv) check("aw_stable", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
            if (p_wv && p_wr) begin check("w_drop", axi.wvalid, 0); w_ok = 1; end
            else if (p_wv) check("w_stable", {axi.wvalid, axi.wstrb, axi.wdata}, {1'b1, p_wstrb, p_wdata});
            if (p_rv && p_rr) ar_ok = 0;
            if (p_bv && p_br) begin aw_ok = 0; w_ok = 0; end
            if (p_rsv && !p_rsr)
                check("resp_stable", {resp_valid, resp_err, resp_rdata}, {1'b1, p_err, p_rdata});
        end
        if (axi.rready) check("rready_before_ar", ar_ok, 1);
        if (axi.bready) check("bready_before_aw_w", aw_ok && w_ok, 1);
        if (resp_valid && resp_ready) n_resp++;
        p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
        p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
        p_wv = axi.wvalid; p_wr = axi.wready; p_wdata = axi.wdata; p_wstrb = axi.wstrb;
        p_rv = axi.rvalid; p_rr = axi.rready; p_bv = axi.bvalid; p_br = axi.bready;
        p_rsv = resp_valid; p_rsr = resp_ready; p_rdata = resp_rdata; p_err = resp_err;
        p_valid = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk); #1;
    endtask

    // One complete CPU transaction; lat counts cycles from acceptance to resp_valid.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold, input bit noise,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        step();
        req_valid = 1'b0;
        n_req++;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            check("req_ready_busy", req_ready, 0);
            if (noise) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
            end
            step();
            lat++;
        end
        req_valid = 1'b0;
        rdata = resp_rdata;
        err   = resp_err;
        if (!resp_valid) begin
            check("resp_timeout", resp_valid, 1);
            return;
        end
        repeat (hold) begin check("req_ready_in_resp", req_ready, 0); step(); end
        resp_ready = 1'b1;
        check("req_ready_in_resp", req_ready, 0);
        step();
        resp_ready = 1'b0;
        check("resp_drop", resp_valid, 0);
        check("req_ready_after_resp", req_ready, 1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rd_val;
        logic [1:0]  bresp;
        int          ar, r, aw, w, b, hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] got_rdata;
        logic        got_err;
        int          got_lat;

        vecs[0] = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, BRESP_OKAY, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[1] = '{1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0011, 32'h0, BRESP_OKAY, 0, 0, 0, 3, 0, 0, 32'h0, 1'b0, 6};
        vecs[2] = '{1'b1, 32'h8000_0024, 32'hA5A5_0F0F, 4'hF, 32'h0, BRESP_SLVERR, 0, 0, 0, 0, 0, 0, 32'h0, 1'b1, 3};
        vecs[3] = '{1'b0, 32'h8000_0030, 32'h0, 4'h0, 32'hCAFE_F00D, BRESP_OKAY, 2, 1, 0, 0, 0, 5, 32'hCAFE_F00D, 1'b0, 6};
        vecs[4] = '{1'b1, 32'h8000_0034, 32'hFFFF_0000, 4'b1100, 32'h0, BRESP_DECERR, 0, 0, 2, 0, 2, 0, 32'h0, 1'b1, 7};
        vecs[5] = '{1'b0, 32'h8000_0040, 32'h0, 4'h0, 32'h1357_9BDF, BRESP_OKAY, 0, 3, 0, 0, 0, 0, 32'h1357_9BDF, 1'b0, 6};
        vecs[6] = '{1'b1, 32'h8000_0038, 32'h0000_0001, 4'b0001, 32'h0, BRESP_OKAY, 0, 0, 1, 1, 0, 1, 32'h0, 1'b0, 4};

        rst = 1'b1; spur = 0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
        ar_cfg = 0; r_cfg = 0; aw_cfg = 0; w_cfg = 0; b_cfg = 0; rd_val = '0; bresp_val = BRESP_OKAY;
        mon_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, resp_valid}, 6'b0);
        check("rst_resp", {resp_err, resp_rdata}, 33'h0);
        check("rst_payload", {axi.araddr, axi.awaddr}, 64'h0);
        check("rst_wpayload", {axi.wstrb, axi.wdata}, 36'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            ar_cfg = vecs[i].ar; r_cfg = vecs[i].r; aw_cfg = vecs[i].aw; w_cfg = vecs[i].w; b_cfg = vecs[i].b;
            rd_val = vecs[i].rd_val; bresp_val = vecs[i].bresp;
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].hold, 1'b0,
                   got_rdata, got_err, got_lat);
            check($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), got_err, vecs[i].exp_err);
            check($sformatf("vec%0d_latency", i), got_lat, vecs[i].exp_lat);
            if (vecs[i].we) begin
                check($sformatf("vec%0d_awaddr", i), cap_awaddr, vecs[i].addr);
                check($sformatf("vec%0d_wdata", i), {cap_wstrb, cap_wdata}, {vecs[i].strb, vecs[i].wdata});
            end else begin
                check($sformatf("vec%0d_araddr", i), cap_araddr, vecs[i].addr);
            end
        end

        // Reset while AR is stalled
        ar_cfg = 30; r_cfg = 0; rd_val = 32'h7777_0001;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0050;
        step();
        req_valid = 1'b0;
        step();
        check("pre_rst_arvalid", axi.arvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_arvalid", axi.arvalid, 0);
        check("async_rst_idle", req_ready, 1);
        check("async_rst_resp", resp_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        mon_clear();
        @(posedge clk); #1;
        repeat (4) begin check("post_rst_no_resp", resp_valid, 0); step(); end
        ar_cfg = 0; rd_val = 32'h0F1E_2D3C;
        do_req(1'b0, 32'h8000_0054, 32'h0, 4'h0, 0, 1'b0, got_rdata, got_err, got_lat);
        check("post_rst_rdata", got_rdata, 32'h0F1E_2D3C);
        check("post_rst_latency", got_lat, 3);

        // Spurious R/B in IDLE must not be acknowledged
        spur = 1;
        repeat (3) begin
            step();
            check("spur_ready", {axi.rready, axi.bready}, 2'b00);
            check("spur_state", {req_ready, resp_valid}, 2'b10);
        end
        spur = 0;
        step();
        rd_val = 32'h2468_ACE0;
        do_req(1'b0, 32'h8000_0058, 32'h0, 4'h0, 0, 1'b0, got_rdata, got_err, got_lat);
        check("post_spur_rdata", {got_err, got_rdata}, {1'b0, 32'h2468_ACE0});

        // Randomized back-to-back traffic
        for (int t = 0; t < 60; t++) begin
            logic        we;
            logic [31:0] addr, wdata;
            logic [3:0]  strb;
            logic [31:0] exp_rdata;
            logic        exp_err;
            int          exp_lat, hold;
            we = 1'($urandom_range(0, 1));
            addr = $urandom; wdata = $urandom; strb = 4'($urandom_range(0, 15));
            rd_val = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    bresp_val = BRESP_OKAY;
                2:       bresp_val = BRESP_SLVERR;
                default: bresp_val = BRESP_DECERR;
            endcase
            ar_cfg = $urandom_range(0, 7); r_cfg = $urandom_range(0, 7);
            aw_cfg = $urandom_range(0, 7); w_cfg = $urandom_range(0, 7); b_cfg = $urandom_range(0, 7);
            hold = $urandom_range(0, 3);
            exp_rdata = we ? 32'h0 : rd_val;
            exp_err   = we ? (bresp_val != 2'b00) : 1'b0;
            exp_lat   = we ? 3 + ((aw_cfg > w_cfg) ? aw_cfg : w_cfg) + b_cfg : 3 + ar_cfg + r_cfg;
            do_req(we, addr, wdata, strb, hold, 1'b1, got_rdata, got_err, got_lat);
            check($sformatf("rnd%0d_resp", t), {got_err, got_rdata}, {exp_err, exp_rdata});
            check($sformatf("rnd%0d_latency", t), got_lat, exp_lat);
            if (we) check($sformatf("rnd%0d_wpayload", t), {cap_awaddr, cap_wstrb, cap_wdata}, {addr, strb, wdata});
            else    check($sformatf("rnd%0d_araddr", t), cap_araddr, addr);
        end

        step();
        check("resp_count", n_resp, n_req);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
